// File: rtl/maze_pkg.sv
// Shared constants, encodings and helpers for the 5x5 maze environment driver.
package maze_pkg;

    localparam int unsigned GRID_W        = 5;
    localparam logic [5:0]  GOAL          = 6'd25;
    localparam logic [5:0]  START_DEFAULT = 6'd1;

    // Bit (s-1) set for each hole state s in {3,4,7,13,14,17,19,22}
    localparam logic [24:0] HOLE_MASK = 25'h025_304C;

    localparam logic [15:0] R_GOAL    = 16'h0064;
    localparam logic [15:0] R_HOLE    = 16'hFF9C;
    localparam logic [15:0] R_TIMEOUT = 16'hFFCE;
    localparam logic [15:0] R_NONE    = 16'h0000;

    typedef enum logic [1:0] {
        ACT_UP    = 2'd0,
        ACT_RIGHT = 2'd1,
        ACT_DOWN  = 2'd2,
        ACT_LEFT  = 2'd3
    } action_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_DRIVE,
        ST_ADVANCE,
        ST_FINISH
    } fsm_e;

    function automatic logic is_hole(input logic [5:0] s);
        logic [31:0] m;
        m = {7'b0, HOLE_MASK};
        return (s != 6'd0) && m[5'(s - 6'd1)];
    endfunction

    // Fibonacci form of x^16+x^14+x^13+x^11
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

endpackage

// File: rtl/maze_step_logic.sv
// Combinational grid move: (state, action, step_cnt) -> next_state, reward, episode end.
module maze_step_logic
    import maze_pkg::*;
#(
    parameter int unsigned MAX_STEPS = 16
) (
    input  logic [5:0]  state,
    input  logic [1:0]  action,
    input  logic [4:0]  step_cnt,
    output logic [5:0]  next_state,
    output logic [15:0] reward,
    output logic        episode_end
);

    logic [2:0] row;
    logic [2:0] col;
    logic       at_goal;
    logic       at_hole;
    logic       timeout;

    always_comb begin
        row        = 3'((state - 6'd1) / 6'(GRID_W));
        col        = 3'((state - 6'd1) % 6'(GRID_W));
        next_state = state;
        case (action)
            ACT_UP:    if (row != 3'd0)              next_state = state - 6'(GRID_W);
            ACT_RIGHT: if (col != 3'(GRID_W - 1))    next_state = state + 6'd1;
            ACT_DOWN:  if (row != 3'(GRID_W - 1))    next_state = state + 6'(GRID_W);
            ACT_LEFT:  if (col != 3'd0)              next_state = state - 6'd1;
            default:   next_state = state;
        endcase

        at_goal = (next_state == GOAL);
        at_hole = is_hole(next_state);
        timeout = (step_cnt == 5'(MAX_STEPS - 1));

        if (at_goal)       reward = R_GOAL;
        else if (timeout)  reward = R_TIMEOUT;
        else if (at_hole)  reward = R_HOLE;
        else               reward = R_NONE;

        episode_end = at_goal || at_hole || timeout;
    end

endmodule

// File: rtl/maze_env_driver.sv
// Maze environment / agent sequencer producing Q-update tuples and the en strobe
// for the Q-learning accelerator, over NUM_EPISODES episodes.
module maze_env_driver
    import maze_pkg::*;
#(
    parameter int unsigned UPDATE_CYCLES = 3,
    parameter int unsigned MAX_STEPS     = 16,
    parameter int unsigned NUM_EPISODES  = 100,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        act_mode,
    input  logic [1:0]  ext_action,
    input  logic [5:0]  start_state,
    input  logic [3:0]  alpha_cfg,
    input  logic [3:0]  gamma_cfg,
    output logic        en,
    output logic [3:0]  action,
    output logic [5:0]  state,
    output logic [5:0]  next_state,
    output logic [15:0] reward,
    output logic [3:0]  alpha,
    output logic [3:0]  gamma,
    output logic        busy,
    output logic        done,
    output logic [15:0] episode_cnt,
    output logic [4:0]  step_cnt
);

    fsm_e        fsm;
    logic [15:0] lfsr;
    logic [5:0]  start_lat;
    logic [7:0]  drive_cnt;
    logic        ep_end_q;

    logic [1:0]  sel_action;
    logic [5:0]  ns_c;
    logic [15:0] rw_c;
    logic        end_c;
    logic [15:0] ep_inc;

    assign sel_action = act_mode ? ext_action : lfsr[1:0];
    assign ep_inc     = episode_cnt + 16'd1;

    maze_step_logic #(
        .MAX_STEPS(MAX_STEPS)
    ) u_step (
        .state       (state),
        .action      (sel_action),
        .step_cnt    (step_cnt),
        .next_state  (ns_c),
        .reward      (rw_c),
        .episode_end (end_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm         <= ST_IDLE;
            lfsr        <= LFSR_SEED;
            start_lat   <= START_DEFAULT;
            drive_cnt   <= '0;
            ep_end_q    <= 1'b0;
            en          <= 1'b0;
            action      <= '0;
            state       <= START_DEFAULT;
            next_state  <= START_DEFAULT;
            reward      <= '0;
            alpha       <= '0;
            gamma       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            episode_cnt <= '0;
            step_cnt    <= '0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (start) begin
                        alpha       <= alpha_cfg;
                        gamma       <= gamma_cfg;
                        start_lat   <= start_state;
                        state       <= start_state;
                        step_cnt    <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        episode_cnt <= '0;
                        fsm         <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    action     <= {2'b00, sel_action};
                    next_state <= ns_c;
                    reward     <= rw_c;
                    ep_end_q   <= end_c;
                    lfsr       <= lfsr_next(lfsr);
                    drive_cnt  <= '0;
                    en         <= 1'b1;
                    fsm        <= ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (drive_cnt == 8'(UPDATE_CYCLES - 1)) begin
                        en  <= 1'b0;
                        fsm <= ST_ADVANCE;
                    end else begin
                        drive_cnt <= drive_cnt + 8'd1;
                    end
                end
                ST_ADVANCE: begin
                    if (ep_end_q) begin
                        episode_cnt <= ep_inc;
                        state       <= start_lat;
                        step_cnt    <= '0;
                        // busy/done flip here so they are already valid in FINISH
                        if (ep_inc == 16'(NUM_EPISODES)) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            fsm  <= ST_FINISH;
                        end else begin
                            fsm <= ST_SELECT;
                        end
                    end else begin
                        state    <= next_state;
                        step_cnt <= step_cnt + 5'd1;
                        fsm      <= ST_SELECT;
                    end
                end
                ST_FINISH: fsm <= ST_IDLE;
                default:   fsm <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_env_driver.sv
// Directed bench for maze_env_driver (NUM_EPISODES overridden to 2 so the
// completion path is reachable in a short run).
module tb_maze_env_driver;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        act_mode;
    logic [1:0]  ext_action;
    logic [5:0]  start_state;
    logic [3:0]  alpha_cfg;
    logic [3:0]  gamma_cfg;
    logic        en;
    logic [3:0]  action;
    logic [5:0]  state;
    logic [5:0]  next_state;
    logic [15:0] reward;
    logic [3:0]  alpha;
    logic [3:0]  gamma;
    logic        busy;
    logic        done;
    logic [15:0] episode_cnt;
    logic [4:0]  step_cnt;

    int errors = 0;
    int checks = 0;

    maze_env_driver #(
        .UPDATE_CYCLES(3),
        .MAX_STEPS(16),
        .NUM_EPISODES(2),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .act_mode    (act_mode),
        .ext_action  (ext_action),
        .start_state (start_state),
        .alpha_cfg   (alpha_cfg),
        .gamma_cfg   (gamma_cfg),
        .en          (en),
        .action      (action),
        .state       (state),
        .next_state  (next_state),
        .reward      (reward),
        .alpha       (alpha),
        .gamma       (gamma),
        .busy        (busy),
        .done        (done),
        .episode_cnt (episode_cnt),
        .step_cnt    (step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    // Leaves the DUT at the sample point of its first SELECT cycle
    task automatic do_start(input logic [5:0] s);
        start_state = s;
        start       = 1'b1;
        tick(1);
        start       = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        start       = 1'b1;
        act_mode    = 1'b1;
        ext_action  = 2'd1;
        start_state = 6'd5;
        alpha_cfg   = 4'h3;
        gamma_cfg   = 4'h9;

        // Reset held with start asserted
        tick(2);
        chk("rst_en",      32'(en),          32'd0);
        chk("rst_state",   32'(state),       32'd1);
        chk("rst_next",    32'(next_state),  32'd1);
        chk("rst_reward",  32'(reward),      32'd0);
        chk("rst_busy",    32'(busy),        32'd0);
        chk("rst_done",    32'(done),        32'd0);
        chk("rst_epcnt",   32'(episode_cnt), 32'd0);
        chk("rst_stepcnt", 32'(step_cnt),    32'd0);
        chk("rst_action",  32'(action),      32'd0);
        chk("rst_alpha",   32'(alpha),       32'd0);

        // Start from state 1, move right into state 2
        rst_n = 1'b1;
        do_start(6'd1);
        chk("sel_busy",  32'(busy),  32'd1);
        chk("sel_en",    32'(en),    32'd0);
        chk("sel_state", 32'(state), 32'd1);
        chk("sel_alpha", 32'(alpha), 32'h3);
        chk("sel_gamma", 32'(gamma), 32'h9);
        tick(1);
        chk("s1_en",     32'(en),         32'd1);
        chk("s1_action", 32'(action),     32'd1);
        chk("s1_next",   32'(next_state), 32'd2);
        chk("s1_reward", 32'(reward),     32'd0);
        // start while busy must be ignored, including its start_state
        start       = 1'b1;
        start_state = 6'd24;
        tick(1);
        start = 1'b0;
        chk("s1_en_d2", 32'(en),    32'd1);
        chk("s1_st_d2", 32'(state), 32'd1);
        tick(1);
        chk("s1_en_d3", 32'(en),         32'd1);
        chk("s1_nx_d3", 32'(next_state), 32'd2);
        tick(1);
        chk("s1_en_adv", 32'(en), 32'd0);
        tick(1);
        chk("s2_state",   32'(state),    32'd2);
        chk("s2_stepcnt", 32'(step_cnt), 32'd1);

        // Right again into hole 3
        tick(1);
        chk("s2_next",   32'(next_state), 32'd3);
        chk("s2_reward", 32'(reward),     32'h0000_FF9C);
        tick(4);
        chk("hole_epcnt",   32'(episode_cnt), 32'd1);
        chk("hole_state",   32'(state),       32'd1);
        chk("hole_stepcnt", 32'(step_cnt),    32'd0);
        chk("hole_busy",    32'(busy),        32'd1);

        // Reset in the middle of DRIVE
        tick(2);
        chk("md_en_pre", 32'(en), 32'd1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("md_en",    32'(en),          32'd0);
        chk("md_state", 32'(state),       32'd1);
        chk("md_next",  32'(next_state),  32'd1);
        chk("md_epcnt", 32'(episode_cnt), 32'd0);
        chk("md_busy",  32'(busy),        32'd0);
        tick(2);
        chk("md_idle_en",   32'(en),   32'd0);
        chk("md_idle_busy", 32'(busy), 32'd0);

        // Walls: up and left from state 1
        ext_action = 2'd0;
        do_start(6'd1);
        tick(1);
        chk("wall_up_next", 32'(next_state), 32'd1);
        chk("wall_up_rew",  32'(reward),     32'd0);
        chk("wall_up_act",  32'(action),     32'd0);
        tick(4);
        chk("wall_up_step", 32'(step_cnt), 32'd1);
        ext_action = 2'd3;
        tick(1);
        chk("wall_lf_next", 32'(next_state), 32'd1);
        chk("wall_lf_rew",  32'(reward),     32'd0);
        chk("wall_lf_act",  32'(action),     32'd3);
        do_reset();

        // Step limit: alternate right/left for 16 steps
        do_start(6'd1);
        for (int k = 0; k < 16; k++) begin
            ext_action = (k % 2 == 0) ? 2'd1 : 2'd3;
            tick(1);
            chk("to_stepcnt", 32'(step_cnt),   32'(k));
            chk("to_next",    32'(next_state), (k % 2 == 0) ? 32'd2 : 32'd1);
            chk("to_reward",  32'(reward),     (k == 15) ? 32'h0000_FFCE : 32'd0);
            tick(4);
        end
        chk("to_end_step",  32'(step_cnt),    32'd0);
        chk("to_end_epcnt", 32'(episode_cnt), 32'd1);
        chk("to_end_state", 32'(state),       32'd1);
        do_reset();

        // Goal from 24 (right) and from 20 (down)
        ext_action = 2'd1;
        do_start(6'd24);
        tick(1);
        chk("g24_next",   32'(next_state), 32'd25);
        chk("g24_reward", 32'(reward),     32'h0000_0064);
        tick(4);
        chk("g24_epcnt", 32'(episode_cnt), 32'd1);
        chk("g24_state", 32'(state),       32'd24);
        do_reset();
        ext_action = 2'd2;
        do_start(6'd20);
        tick(1);
        chk("g20_next",   32'(next_state), 32'd25);
        chk("g20_reward", 32'(reward),     32'h0000_0064);
        tick(4);
        chk("g20_epcnt", 32'(episode_cnt), 32'd1);
        do_reset();

        // Goal on the last allowed step: reward 100, a single episode end
        do_start(6'd24);
        for (int k = 0; k < 16; k++) begin
            if (k == 0)           ext_action = 2'd2;
            else if (k == 15)     ext_action = 2'd1;
            else if (k % 2 == 1)  ext_action = 2'd3;
            else                  ext_action = 2'd1;
            tick(5);
        end
        chk("gl_epcnt", 32'(episode_cnt), 32'd1);
        chk("gl_busy",  32'(busy),        32'd1);
        chk("gl_done",  32'(done),        32'd0);
        chk("gl_step",  32'(step_cnt),    32'd0);
        chk("gl_state", 32'(state),       32'd24);
        tick(1);
        chk("gl_after_next", 32'(next_state), 32'd25);
        do_reset();

        // LFSR-driven actions: seed ACE1 gives right, then up (wall at state 2)
        act_mode   = 1'b0;
        ext_action = 2'd3;
        do_start(6'd1);
        tick(1);
        chk("lfsr_act1",  32'(action),     32'd1);
        chk("lfsr_next1", 32'(next_state), 32'd2);
        tick(5);
        chk("lfsr_act2",  32'(action),     32'd0);
        chk("lfsr_next2", 32'(next_state), 32'd2);
        do_reset();
        act_mode = 1'b1;

        // Two one-step hole episodes complete the run
        ext_action = 2'd1;
        do_start(6'd2);
        tick(1);
        chk("fin_rew1", 32'(reward), 32'h0000_FF9C);
        tick(4);
        chk("fin_ep1",  32'(episode_cnt), 32'd1);
        chk("fin_st1",  32'(state),       32'd2);
        tick(5);
        chk("fin_epcnt", 32'(episode_cnt), 32'd2);
        chk("fin_busy",  32'(busy),        32'd0);
        chk("fin_done",  32'(done),        32'd1);
        chk("fin_en",    32'(en),          32'd0);
        tick(3);
        chk("fin_done_sticky", 32'(done), 32'd1);
        chk("fin_en_idle",     32'(en),   32'd0);
        do_start(6'd2);
        chk("re_epcnt", 32'(episode_cnt), 32'd0);
        chk("re_done",  32'(done),        32'd0);
        chk("re_busy",  32'(busy),        32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
